lsu_byte_sequencer: RTL

- Load/store sequencer directly upstream of the byte-wide data RAM.
- Accepts one CPU memory request (byte/half/word, load or store) over a valid/ready handshake.
- Checks alignment, then issues one RAM byte access per cycle, big-endian: the byte at the base address is the most significant.
- Assembles or extends load data and returns a single response beat carrying data or an exception flag.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/load_extend.sv | 23 ++
 rtl/lsu_byte_sequencer.sv | 110 +++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared load/store definitions: access size encodings, sequencer states,
// byte-count and alignment helpers.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_XFER = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // The illegal size reports one byte so downstream arithmetic stays in range;
    // such requests never reach the transfer state anyway.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        case (size)
            SZ_HALF: size_to_bytes = 3'd2;
            SZ_WORD: size_to_bytes = 3'd4;
            default: size_to_bytes = 3'd1;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = addr_lo[0];
            SZ_WORD: misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of a right-justified byte or half; words pass through.
// Purely combinational.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    output logic [31:0] ext_o
);

    always_comb begin
        ext_o = data_i;
        case (size_i)
            SZ_BYTE: ext_o = uns_i ? {24'h000000, data_i[7:0]}
                                   : {{24{data_i[7]}}, data_i[7:0]};
            SZ_HALF: ext_o = uns_i ? {16'h0000, data_i[15:0]}
                                   : {{16{data_i[15]}}, data_i[15:0]};
            default: ext_o = data_i;
        endcase
    end

endmodule

// File: rtl/lsu_byte_sequencer.sv
// Serialises one CPU load/store into big-endian byte RAM accesses (1/2/4 cycles),
// then returns a single unbackpressured response beat; exceptions respond next cycle.
module lsu_byte_sequencer
    import mem_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_exc,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    state_t            state_q;
    logic [1:0]        count_q;
    logic [31:0]       data_q;
    logic              exc_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic [1:0]        last_idx;
    logic [1:0]        byte_idx;
    logic [31:0]       ext_data;
    logic              in_xfer;
    logic              in_resp;

    assign last_idx = 2'(size_to_bytes(size_q) - 3'd1);
    // MSB-first: the first beat carries the highest used byte of the store data.
    assign byte_idx = last_idx - count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            data_q  <= '0;
            exc_q   <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        count_q <= '0;
                        exc_q   <= misaligned(req_size, req_addr[1:0]);
                        state_q <= misaligned(req_size, req_addr[1:0]) ? ST_RESP : ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (!we_q) begin
                        data_q <= {data_q[23:0], ram_rdata};
                    end
                    if (count_q == last_idx) begin
                        count_q <= '0;
                        state_q <= ST_RESP;
                    end else begin
                        count_q <= count_q + 2'd1;
                    end
                end
                ST_RESP: begin
                    data_q  <= '0;
                    exc_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    load_extend u_load_extend (
        .data_i (data_q),
        .size_i (size_q),
        .uns_i  (uns_q),
        .ext_o  (ext_data)
    );

    assign in_xfer    = (state_q == ST_XFER);
    assign in_resp    = (state_q == ST_RESP);

    assign req_ready  = (state_q == ST_IDLE);
    assign ram_we     = in_xfer && we_q;
    assign ram_addr   = in_xfer ? addr_q + ADDR_W'(count_q) : '0;
    assign ram_wdata  = ram_we ? wdata_q[{byte_idx, 3'b000} +: 8] : 8'h00;
    assign resp_valid = in_resp;
    assign resp_exc   = in_resp && exc_q;
    assign resp_rdata = (in_resp && !exc_q && !we_q) ? ext_data : 32'h0;

endmodule
